irq_pend_capture: RTL and testbench

- Four-source request capture stage that sits directly upstream of the 4-to-2 priority encoder.
- Converts raw request lines into sticky pending bits, applies an enable mask, and drives the encoder inputs a0..a3.
- The consumer acknowledges the served index with ack/ack_idx, which clears that pending bit.
- Tracks requests lost because a source fired again while already pending (overruns).

---
 rtl/irq_pend_capture.sv | 146 ++++++++++++++
 tb/tb_irq_pend_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_pend_capture.sv
// irq_pend_capture
// Four-source request capture stage feeding a 4-to-2 priority encoder.
// Raw request lines become sticky pending bits. An enable mask gates what is
// presented on a0..a3. The consumer clears the served bit with ack/ack_idx.
// Requests that arrive while the source is already pending are overruns.
// They are flagged per source and counted in a saturating counter.
//
// Optional build macro:
//   IRQ_SYNC_EN - passes req through a 2-flop synchronizer (reset to 0)
//                 before event detection. Request-to-a_i latency becomes
//                 3 cycles instead of 1.
module irq_pend_capture #(
  parameter bit EDGE_MODE = 1'b1,  // 1: rising edge is a request, 0: high level
  parameter int CNT_W     = 8      // width of the saturating drop counter
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       mask,
  input  logic             ack,
  input  logic [1:0]       ack_idx,
  input  logic             ovr_clr,
  output logic             a0,
  output logic             a1,
  output logic             a2,
  output logic             a3,
  output logic             any_pend,
  output logic [3:0]       overrun,
  output logic [CNT_W-1:0] drop_cnt
);

  // The sum is wide enough for base + 4 and for the carry out of the counter.
  localparam int SUM_W = ((CNT_W > 3) ? CNT_W : 3) + 1;

  logic [3:0]       w_req_s;      // request lines as seen by event detection
  logic [3:0]       r_req_d;      // previous sample of w_req_s
  logic [3:0]       r_pend;
  logic [3:0]       r_overrun;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [3:0]       w_event;
  logic [3:0]       w_clr;
  logic [3:0]       w_ovr;
  logic [3:0]       w_pend_next;
  logic [3:0]       w_a;
  logic [2:0]       w_ovr_cnt;
  logic [3:0]       w_ovr_base;
  logic [CNT_W-1:0] w_cnt_base;
  logic [SUM_W-1:0] w_cnt_sum;
  logic [SUM_W-1:0] w_cnt_max;
  logic [CNT_W-1:0] w_cnt_next;

`ifdef IRQ_SYNC_EN
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  // Two-flop synchronizer for asynchronous request sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= req;
      r_sync2 <= r_sync1;
    end
  end

  assign w_req_s = r_sync2;
`else
  assign w_req_s = req;
`endif

  // Event detection: rising edge or sampled-high level.
  assign w_event = EDGE_MODE ? (w_req_s & ~r_req_d) : w_req_s;

  // One-hot clear for the index being acknowledged.
  assign w_clr = ack ? (4'b0001 << ack_idx) : 4'b0000;

  // A new event on a source that stays pending is a lost request.
  assign w_ovr = w_event & r_pend & ~w_clr;

  // If set and clear hit the same bit in the same cycle, the set wins.
  assign w_pend_next = (r_pend & ~w_clr) | w_event;

  // Count the overrun events of this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_ovr_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      w_ovr_cnt = w_ovr_cnt + 3'(w_ovr[i]);
    end
  end

  // Overrun flags and counter: ovr_clr wipes the old state, and new events of
  // the same cycle are then applied on top of it.
  assign w_ovr_base = ovr_clr ? 4'b0000 : r_overrun;
  assign w_cnt_base = ovr_clr ? '0 : r_drop_cnt;
  assign w_cnt_sum  = SUM_W'(w_cnt_base) + SUM_W'(w_ovr_cnt);
  assign w_cnt_max  = SUM_W'({CNT_W{1'b1}});

  // Saturate the counter instead of letting it wrap.
  always_comb begin
    w_cnt_next = w_cnt_sum[CNT_W-1:0];
    if (w_cnt_sum > w_cnt_max) begin
      w_cnt_next = {CNT_W{1'b1}};
    end
  end

  // Previous-sample register. It resets to all ones so that a line held high
  // through reset does not look like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_d <= 4'b1111;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, whatever the statement order.
      r_req_d <= w_req_s;
    end
  end

  // Pending, overrun and drop-counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= 4'b0000;
      r_overrun  <= 4'b0000;
      r_drop_cnt <= '0;
    end else begin
      r_pend     <= w_pend_next;
      r_overrun  <= w_ovr_base | w_ovr;
      r_drop_cnt <= w_cnt_next;
    end
  end

  // Encoder inputs are combinational from pend and the live mask, so a mask
  // change shows up in the same cycle.
  assign w_a      = r_pend & mask;
  assign a0       = w_a[0];
  assign a1       = w_a[1];
  assign a2       = w_a[2];
  assign a3       = w_a[3];
  assign any_pend = |w_a;
  assign overrun  = r_overrun;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_irq_pend_capture.sv
// Directed testbench for irq_pend_capture (edge mode, 2-bit drop counter).
// With IRQ_SYNC_EN defined, a reduced sequence covers the synchronizer latency.
module tb_irq_pend_capture;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0]       mask;
  logic             ack;
  logic [1:0]       ack_idx;
  logic             ovr_clr;
  logic             a0, a1, a2, a3;
  logic             any_pend;
  logic [3:0]       overrun;
  logic [CNT_W-1:0] drop_cnt;
  logic [3:0]       a_vec;

  int n_checks = 0;
  int n_errors = 0;

  irq_pend_capture #(
    .EDGE_MODE(1'b1),
    .CNT_W    (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mask    (mask),
    .ack     (ack),
    .ack_idx (ack_idx),
    .ovr_clr (ovr_clr),
    .a0      (a0),
    .a1      (a1),
    .a2      (a2),
    .a3      (a3),
    .any_pend(any_pend),
    .overrun (overrun),
    .drop_cnt(drop_cnt)
  );

  assign a_vec = {a3, a2, a1, a0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive req for one cycle, then return it to zero.
  task automatic pulse(input logic [3:0] v);
    req = v;
    tick();
    req = 4'b0000;
  endtask

  task automatic do_ack(input logic [1:0] idx);
    ack     = 1'b1;
    ack_idx = idx;
    tick();
    ack     = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b0100;
    mask    = 4'b1111;
    ack     = 1'b0;
    ack_idx = 2'd0;
    ovr_clr = 1'b0;
    repeat (3) tick();
    check("reset_a",        8'(a_vec),    8'h0);
    check("reset_any",      8'(any_pend), 8'h0);
    check("reset_overrun",  8'(overrun),  8'h0);
    check("reset_drop",     8'(drop_cnt), 8'h0);

`ifdef IRQ_SYNC_EN
    // Synchronizer: req[3] sampled at edge N reaches a3 after edge N+2.
    req = 4'b0000;
    rst = 1'b0;
    repeat (4) tick();
    do_ack(2'd2);                 // drop any start-up capture
    check("sync_idle", 8'(a_vec), 8'h0);
    pulse(4'b1000);               // sampling edge N
    check("sync_lat1", 8'(a3), 8'h0);
    tick();
    check("sync_lat2", 8'(a3), 8'h0);
    tick();
    check("sync_lat3", 8'(a3), 8'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sync_rst_a",   8'(a_vec),    8'h0);
    check("sync_rst_any", 8'(any_pend), 8'h0);
`else
    // 1: a line held high through reset is not an edge.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("held_no_edge", 8'(a2), 8'h0);
    end
    req = 4'b0000;
    tick();
    pulse(4'b0100);
    check("edge_a2",  8'(a2),       8'h1);
    check("edge_any", 8'(any_pend), 8'h1);
    check("edge_vec", 8'(a_vec),    8'h4);
    do_ack(2'd2);
    check("ack2_clear", 8'(a_vec), 8'h0);

    // 2: two sources pending, acked one at a time.
    pulse(4'b1010);
    check("two_pend", 8'(a_vec), 8'hA);
    do_ack(2'd3);
    check("ack3_vec", 8'(a_vec), 8'h2);
    do_ack(2'd1);
    check("ack1_vec", 8'(a_vec),    8'h0);
    check("ack1_any", 8'(any_pend), 8'h0);
    do_ack(2'd0);                 // ack to a non-pending index
    check("ack_idle_vec", 8'(a_vec),   8'h0);
    check("ack_idle_ovr", 8'(overrun), 8'h0);

    // 3: masked pending bit is held and appears when unmasked.
    mask = 4'b1110;
    pulse(4'b0001);
    check("masked_a0",  8'(a0),       8'h0);
    check("masked_any", 8'(any_pend), 8'h0);
    mask = 4'b1111;
    #1;
    check("unmask_a0",  8'(a0),       8'h1);
    check("unmask_any", 8'(any_pend), 8'h1);
    mask = 4'b1110;               // ack clears pend even while masked
    do_ack(2'd0);
    mask = 4'b1111;
    #1;
    check("masked_ack", 8'(a0), 8'h0);

    // 4: set beats clear, no overrun; later repeat event is an overrun.
    pulse(4'b0100);
    tick();
    req     = 4'b0100;
    ack     = 1'b1;
    ack_idx = 2'd2;
    tick();
    req = 4'b0000;
    ack = 1'b0;
    check("setwins_a2",  8'(a2),      8'h1);
    check("setwins_ovr", 8'(overrun), 8'h0);
    tick();
    pulse(4'b0100);
    check("ovr2_flag", 8'(overrun),  8'h4);
    check("ovr2_cnt",  8'(drop_cnt), 8'h1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovrclr4_flag", 8'(overrun),  8'h0);
    check("ovrclr4_cnt",  8'(drop_cnt), 8'h0);
    check("ovrclr4_a2",   8'(a2),       8'h1);
    do_ack(2'd2);

    // 5: counter saturates at 3 on the 2-bit build.
    pulse(4'b0010);
    tick();
    for (int k = 1; k <= 5; k++) begin
      pulse(4'b0010);
      check("sat_cnt", 8'(drop_cnt), (k < 3) ? 8'(k) : 8'h3);
      tick();
    end
    check("sat_flag", 8'(overrun), 8'h2);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("clr_flag", 8'(overrun),  8'h0);
    check("clr_cnt",  8'(drop_cnt), 8'h0);
    // ovr_clr together with a new overrun: the new event survives.
    ovr_clr = 1'b1;
    pulse(4'b0010);
    ovr_clr = 1'b0;
    check("clrset_flag", 8'(overrun),  8'h2);
    check("clrset_cnt",  8'(drop_cnt), 8'h1);

    // 6: reset mid-operation discards everything, including the req of the
    // reset cycle; the line held high afterwards produces no edge.
    pulse(4'b1001);
    check("pre_rst_vec", 8'(a_vec), 8'hB);
    rst = 1'b1;
    req = 4'b0001;
    tick();
    rst = 1'b0;
    check("midrst_vec",  8'(a_vec),    8'h0);
    check("midrst_any",  8'(any_pend), 8'h0);
    check("midrst_ovr",  8'(overrun),  8'h0);
    check("midrst_cnt",  8'(drop_cnt), 8'h0);
    tick();
    check("post_rst_held", 8'(a0), 8'h0);
    req = 4'b0000;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
